// File: rtl/friscv_icache_blocks_if.sv
// rtl/friscv_icache_blocks_if.sv - icache line storage write and lookup ports
// Master side is the memory controller plus fetcher; slave side is the line storage.
interface friscv_icache_blocks_if #(
  parameter int ADDR_W        = 32,
  parameter int ILEN          = 32,
  parameter int CACHE_BLOCK_W = 128
);
  logic                     wen;
  logic [ADDR_W-1:0]        waddr;
  logic [CACHE_BLOCK_W-1:0] wdata;
  logic                     p_en;
  logic [ADDR_W-1:0]        p_addr;
  logic                     p_hit;
  logic                     p_miss;
  logic [ILEN-1:0]          p_instr;

  modport master (
    output wen, waddr, wdata, p_en, p_addr,
    input  p_hit, p_miss, p_instr
  );

  modport slave (
    input  wen, waddr, wdata, p_en, p_addr,
    output p_hit, p_miss, p_instr
  );
endinterface

// File: rtl/friscv_icache_blocks.sv
// rtl/friscv_icache_blocks.sv - direct-mapped icache data/tag/valid arrays
// Lookups register hit/miss/instruction one cycle later, reading array state before same-edge writes.
module friscv_icache_blocks #(
  parameter int ADDR_W        = 32,
  parameter int ILEN          = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 512
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    flush,
  friscv_icache_blocks_if.slave   p
);

  localparam int OFFSET_W   = $clog2(CACHE_BLOCK_W / 8);
  localparam int INDEX_W    = $clog2(CACHE_DEPTH);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BYTE_OFF_W = $clog2(ILEN / 8);
  localparam int WORDS      = CACHE_BLOCK_W / ILEN;

  logic [CACHE_BLOCK_W-1:0] data_q [CACHE_DEPTH];
  logic [TAG_W-1:0]         tag_q  [CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0]   valid_q, valid_d;
  logic                     hit_q, hit_d;
  logic                     miss_q, miss_d;
  logic [ILEN-1:0]          instr_q, instr_d;

  logic [INDEX_W-1:0]       w_idx, r_idx;
  logic [TAG_W-1:0]         w_tag, r_tag;
  logic [OFFSET_W-1:0]      word_sel;
  logic [CACHE_BLOCK_W-1:0] line_rd;
  logic [ILEN-1:0]          instr_sel;
  logic                     unused_bits;

  assign w_idx    = p.waddr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag    = p.waddr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign r_idx    = p.p_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign r_tag    = p.p_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign word_sel = p.p_addr[OFFSET_W-1:0] >> BYTE_OFF_W;
  assign line_rd  = data_q[r_idx];

  assign unused_bits = ^{p.p_addr[BYTE_OFF_W-1:0], p.waddr[OFFSET_W-1:0]};

  always_comb begin
    instr_sel = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (word_sel == OFFSET_W'(w)) instr_sel = line_rd[w*ILEN +: ILEN];
    end
  end

  always_comb begin
    valid_d = valid_q;
    // Flush dominates: a refill landing in a flush cycle must not resurrect a line.
    if (flush) valid_d = '0;
    else if (p.wen) valid_d[w_idx] = 1'b1;

    hit_d   = p.p_en && !flush && valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    miss_d  = p.p_en && !hit_d;
    instr_d = hit_d ? instr_sel : instr_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      instr_q <= '0;
    end else if (srst) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      instr_q <= instr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (p.wen) begin
      data_q[w_idx] <= p.wdata;
      tag_q[w_idx]  <= w_tag;
    end
  end

  assign p.p_hit   = hit_q;
  assign p.p_miss  = miss_q;
  assign p.p_instr = instr_q;

endmodule
